// File: rtl/frida_pkg.sv
// Shared definitions for the FRIDA on-chip conversion sequencer.
// Contents:
//   - default widths for the ADC count, mux select and conversion counter
//   - the sequencer state enum
//   - the duration clamp (a programmed length of 0 runs as 1 cycle)
//   - the state-to-output decode used for the registered outputs
package frida_pkg;

  localparam int unsigned N_ADC_DEF = 16;
  localparam int unsigned SEL_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Shortest legal phase length, in clk cycles.
  localparam logic [7:0] DUR_MIN = 8'd1;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StSamp,
    StCmp,
    StLogic,
    StDone
  } seq_state_e;

  // Output bit order: {busy, done, seq_logic, seq_cmp, seq_samp, seq_init}.
  localparam int unsigned OUT_W = 6;

  function automatic logic [OUT_W-1:0] state_outs(seq_state_e s);
    logic [OUT_W-1:0] o;
    case (s)
      StInit:  o = 6'b10_0001;
      StSamp:  o = 6'b10_0010;
      StCmp:   o = 6'b10_0100;
      StLogic: o = 6'b10_1000;
      StDone:  o = 6'b11_0000;
      default: o = 6'b00_0000;
    endcase
    return o;
  endfunction

  function automatic logic [7:0] clamp_dur(logic [7:0] v);
    return (v < DUR_MIN) ? DUR_MIN : v;
  endfunction

endpackage

// File: rtl/frida_rr_next.sv
// Round-robin index search over an enable mask (purely combinational).
// Ports:
//   mask  : enable bit per ADC
//   cur   : current mux select
//   incl  : 1 = search starts at cur, 0 = search starts just after cur
//   idx   : first enabled index found, wrapping past N_ADC-1 to 0 (cur when none)
//   found : at least one mask bit is set
// In strict mode the search covers offsets 1..N_ADC, so a lone enabled index
// equal to cur is found again and the select stays put.
module frida_rr_next
  import frida_pkg::*;
#(
  parameter int unsigned N_ADC = N_ADC_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic [N_ADC-1:0] mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             incl,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  int               pos;
  logic [SEL_W-1:0] cand;

  always_comb begin
    idx   = cur;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    // Walk from the farthest offset down so the nearest hit is the last write.
    for (int k = int'(N_ADC) - 1; k >= 0; k--) begin
      pos  = (int'(cur) + k + (incl ? 0 : 1)) % int'(N_ADC);
      cand = pos[SEL_W-1:0];
      if (mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frida_seq_ctrl.sv
// FRIDA conversion sequencer: drives the INIT/SAMP/CMP/LOGIC phase lines of the
// SAR ADC array from programmed durations and steps the comparator mux select
// round-robin over the enabled ADCs.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start              : begin a conversion (sampled in IDLE only)
//   abort              : return to IDLE on the next edge, no completion
//   cfg_continuous     : loop conversions back-to-back (sampled in DONE)
//   cfg_adc_en         : round-robin enable mask (read live at each mux update)
//   cfg_t_*            : phase lengths in clk cycles (0 runs as 1)
//   cfg_n_bits         : CMP/LOGIC pairs per conversion (0 runs as 1)
//   seq_init..seq_logic: registered, mutually exclusive phase lines
//   mux_sel            : registered comparator mux select
//   busy, done         : not-IDLE flag, one-cycle completion pulse
//   conv_cnt           : completed conversions, wrapping
module frida_seq_ctrl
  import frida_pkg::*;
#(
  parameter int unsigned N_ADC = N_ADC_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_continuous,
  input  logic [N_ADC-1:0] cfg_adc_en,
  input  logic [3:0]       cfg_t_init,
  input  logic [7:0]       cfg_t_samp,
  input  logic [3:0]       cfg_t_cmp,
  input  logic [3:0]       cfg_t_logic,
  input  logic [3:0]       cfg_n_bits,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  output logic [SEL_W-1:0] mux_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] conv_cnt
);

  seq_state_e       state_q;
  logic [OUT_W-1:0] outs_q;
  logic [7:0]       dur_q;
  logic [3:0]       bit_q;
  logic [SEL_W-1:0] mux_q;
  logic [CNT_W-1:0] cnt_q;

  // Durations captured at INIT entry; INIT itself loads straight from cfg.
  logic [7:0]       sh_samp_q;
  logic [3:0]       sh_cmp_q;
  logic [3:0]       sh_logic_q;
  logic [3:0]       sh_n_q;

  // Down-counter reload values (clamped length minus one).
  logic [7:0]       init_ld, samp_ld, cmp_ld, logic_ld, bits_ld;

  assign init_ld  = clamp_dur({4'b0000, cfg_t_init}) - 8'd1;
  assign samp_ld  = clamp_dur(sh_samp_q) - 8'd1;
  assign cmp_ld   = clamp_dur({4'b0000, sh_cmp_q}) - 8'd1;
  assign logic_ld = clamp_dur({4'b0000, sh_logic_q}) - 8'd1;
  assign bits_ld  = clamp_dur({4'b0000, sh_n_q}) - 8'd1;

  logic             any_en;
  logic             rr_incl;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;

  assign any_en  = |cfg_adc_en;
  // Inclusive search when leaving IDLE, strict search when leaving DONE.
  assign rr_incl = (state_q == StIdle);

  frida_rr_next #(
    .N_ADC (N_ADC),
    .SEL_W (SEL_W)
  ) u_rr_next (
    .mask  (cfg_adc_en),
    .cur   (mux_q),
    .incl  (rr_incl),
    .idx   (rr_idx),
    .found (rr_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      outs_q     <= '0;
      dur_q      <= '0;
      bit_q      <= '0;
      mux_q      <= '0;
      cnt_q      <= '0;
      sh_samp_q  <= '0;
      sh_cmp_q   <= '0;
      sh_logic_q <= '0;
      sh_n_q     <= '0;
    end else if (abort) begin
      state_q <= StIdle;
      outs_q  <= state_outs(StIdle);
    end else begin
      case (state_q)
        StIdle: begin
          if (start && any_en) begin
            state_q    <= StInit;
            outs_q     <= state_outs(StInit);
            dur_q      <= init_ld;
            mux_q      <= rr_idx;
            sh_samp_q  <= cfg_t_samp;
            sh_cmp_q   <= cfg_t_cmp;
            sh_logic_q <= cfg_t_logic;
            sh_n_q     <= cfg_n_bits;
          end
        end
        StInit: begin
          if (dur_q == 8'd0) begin
            state_q <= StSamp;
            outs_q  <= state_outs(StSamp);
            dur_q   <= samp_ld;
          end else begin
            dur_q <= dur_q - 8'd1;
          end
        end
        StSamp: begin
          if (dur_q == 8'd0) begin
            state_q <= StCmp;
            outs_q  <= state_outs(StCmp);
            dur_q   <= cmp_ld;
            bit_q   <= bits_ld[3:0];
          end else begin
            dur_q <= dur_q - 8'd1;
          end
        end
        StCmp: begin
          if (dur_q == 8'd0) begin
            state_q <= StLogic;
            outs_q  <= state_outs(StLogic);
            dur_q   <= logic_ld;
          end else begin
            dur_q <= dur_q - 8'd1;
          end
        end
        StLogic: begin
          if (dur_q != 8'd0) begin
            dur_q <= dur_q - 8'd1;
          end else if (bit_q != 4'd0) begin
            state_q <= StCmp;
            outs_q  <= state_outs(StCmp);
            dur_q   <= cmp_ld;
            bit_q   <= bit_q - 4'd1;
          end else begin
            // Count on DONE entry so conv_cnt moves in the same cycle done is high.
            state_q <= StDone;
            outs_q  <= state_outs(StDone);
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        StDone: begin
          if (rr_found) begin
            mux_q <= rr_idx;
          end
          if (cfg_continuous && any_en) begin
            state_q    <= StInit;
            outs_q     <= state_outs(StInit);
            dur_q      <= init_ld;
            sh_samp_q  <= cfg_t_samp;
            sh_cmp_q   <= cfg_t_cmp;
            sh_logic_q <= cfg_t_logic;
            sh_n_q     <= cfg_n_bits;
          end else begin
            state_q <= StIdle;
            outs_q  <= state_outs(StIdle);
          end
        end
        default: begin
          state_q <= StIdle;
          outs_q  <= state_outs(StIdle);
        end
      endcase
    end
  end

  assign seq_init  = outs_q[0];
  assign seq_samp  = outs_q[1];
  assign seq_cmp   = outs_q[2];
  assign seq_logic = outs_q[3];
  assign done      = outs_q[4];
  assign busy      = outs_q[5];
  assign mux_sel   = mux_q;
  assign conv_cnt  = cnt_q;

endmodule

// File: tb/tb_frida_seq_ctrl.sv
// Directed bench for frida_seq_ctrl: conversion length and per-phase widths,
// round-robin order, continuous looping, abort, empty mask, shadowed config
// and asynchronous reset. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.
module tb_frida_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cfg_continuous = 1'b0;
  logic [15:0] cfg_adc_en = 16'hFFFF;
  logic [3:0]  cfg_t_init = 4'd1;
  logic [7:0]  cfg_t_samp = 8'd4;
  logic [3:0]  cfg_t_cmp = 4'd2;
  logic [3:0]  cfg_t_logic = 4'd1;
  logic [3:0]  cfg_n_bits = 4'd8;

  logic        seq_init, seq_samp, seq_cmp, seq_logic;
  logic [3:0]  mux_sel;
  logic        busy, done;
  logic [15:0] conv_cnt;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frida_seq_ctrl #(
    .N_ADC (16),
    .SEL_W (4),
    .CNT_W (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_continuous (cfg_continuous),
    .cfg_adc_en     (cfg_adc_en),
    .cfg_t_init     (cfg_t_init),
    .cfg_t_samp     (cfg_t_samp),
    .cfg_t_cmp      (cfg_t_cmp),
    .cfg_t_logic    (cfg_t_logic),
    .cfg_n_bits     (cfg_n_bits),
    .seq_init       (seq_init),
    .seq_samp       (seq_samp),
    .seq_cmp        (seq_cmp),
    .seq_logic      (seq_logic),
    .mux_sel        (mux_sel),
    .busy           (busy),
    .done           (done),
    .conv_cnt       (conv_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, got, exp);
  endtask

  // Hold start for one edge; returns on the first sample after that edge.
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called on the INIT-entry sample; runs through the DONE sample and checks
  // total length, cycles per phase, done count and exclusivity of the lines.
  task automatic expect_conv(input string pfx, input int et, input int ei, input int es,
                             input int ec, input int el);
    int t, ni, ns, nc, nl, nd, bad;
    bit seen;
    t = 0; ni = 0; ns = 0; nc = 0; nl = 0; nd = 0; bad = 0; seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      t++;
      ni += int'(seq_init);
      ns += int'(seq_samp);
      nc += int'(seq_cmp);
      nl += int'(seq_logic);
      nd += int'(done);
      if ($countones({seq_init, seq_samp, seq_cmp, seq_logic, done}) != 1 || !busy) bad++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({pfx, "_done_seen"}, 32'(seen), 32'd1);
    check({pfx, "_len"}, 32'(t), 32'(et));
    check({pfx, "_init"}, 32'(ni), 32'(ei));
    check({pfx, "_samp"}, 32'(ns), 32'(es));
    check({pfx, "_cmp"}, 32'(nc), 32'(ec));
    check({pfx, "_logic"}, 32'(nl), 32'(el));
    check({pfx, "_done_n"}, 32'(nd), 32'd1);
    check({pfx, "_onehot"}, 32'(bad), 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return {20'd0, conv_cnt[3:0], mux_sel, seq_init, seq_samp, seq_cmp, seq_logic, busy, done};
  endfunction

  logic [3:0] rr_exp [4] = '{4'd5, 4'd10, 4'd15, 4'd0};

  initial begin
    int  cmp_entries;
    bit  prev_cmp;

    // Reset state
    tick();
    tick();
    check("rst_outs", all_outs(), 32'd0);
    check("rst_cnt", 32'(conv_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single conversion: 1 + 4 + 8*(2+1) + 1 = 30 cycles
    pulse_start();
    check("t1_init_entry", 32'(seq_init), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_mux_first", 32'(mux_sel), 32'd0);
    expect_conv("t1", 30, 1, 4, 16, 8);
    check("t1_cnt_with_done", 32'(conv_cnt), 32'd1);
    check("t1_mux_in_done", 32'(mux_sel), 32'd0);
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_done", 32'(done), 32'd0);
    check("t1_mux_next", 32'(mux_sel), 32'd1);

    // Continuous round-robin over mask 0x8421 from mux_sel 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_adc_en = 16'h8421;
    cfg_continuous = 1'b1;
    pulse_start();
    check("t2_mux0", 32'(mux_sel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      expect_conv("t2", 30, 1, 4, 16, 8);
      tick();
      check("t2_no_gap", 32'(seq_init), 32'd1);
      check("t2_mux_rr", 32'(mux_sel), 32'(rr_exp[i]));
    end
    // Mask cleared mid-run: this conversion finishes, then IDLE with mux held
    cfg_adc_en = 16'h0000;
    expect_conv("t2m", 30, 1, 4, 16, 8);
    check("t2_cnt", 32'(conv_cnt), 32'd5);
    tick();
    check("t2_mask0_idle", 32'(busy), 32'd0);
    check("t2_mask0_mux", 32'(mux_sel), 32'd0);
    cfg_continuous = 1'b0;

    // All durations 0 and n=0: every phase 1 cycle, T = 5
    cfg_adc_en = 16'hFFFF;
    cfg_t_init = 4'd0;
    cfg_t_samp = 8'd0;
    cfg_t_cmp = 4'd0;
    cfg_t_logic = 4'd0;
    cfg_n_bits = 4'd0;
    pulse_start();
    check("t3_mux", 32'(mux_sel), 32'd0);
    expect_conv("t3", 5, 1, 1, 1, 1);
    tick();
    check("t3_mux_next", 32'(mux_sel), 32'd1);

    // Abort in the 3rd CMP
    cfg_t_init = 4'd1;
    cfg_t_samp = 8'd4;
    cfg_t_cmp = 4'd2;
    cfg_t_logic = 4'd1;
    cfg_n_bits = 4'd8;
    pulse_start();
    cmp_entries = 0;
    prev_cmp = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (seq_cmp && !prev_cmp) cmp_entries++;
      prev_cmp = seq_cmp;
      if (cmp_entries == 3) break;
      tick();
    end
    check("t4_reach_cmp3", 32'(cmp_entries), 32'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_outs", {26'd0, seq_init, seq_samp, seq_cmp, seq_logic, busy, done}, 32'd0);
    check("t4_abort_cnt", 32'(conv_cnt), 32'd6);
    check("t4_abort_mux", 32'(mux_sel), 32'd1);
    tick();
    check("t4_stay_idle", 32'(busy), 32'd0);
    pulse_start();
    check("t4_restart", 32'(seq_init), 32'd1);
    check("t4_restart_mux", 32'(mux_sel), 32'd1);
    expect_conv("t4", 30, 1, 4, 16, 8);
    check("t4_cnt", 32'(conv_cnt), 32'd7);
    tick();
    check("t4_mux_next", 32'(mux_sel), 32'd2);

    // Empty mask ignores start
    cfg_adc_en = 16'h0000;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_init", 32'(seq_init), 32'd0);
    check("t5_cnt", 32'(conv_cnt), 32'd7);

    // t_samp changed mid-conversion applies to the next conversion only
    cfg_adc_en = 16'hFFFF;
    cfg_continuous = 1'b1;
    pulse_start();
    check("t6_mux", 32'(mux_sel), 32'd2);
    cfg_t_samp = 8'd9;
    expect_conv("t6a", 30, 1, 4, 16, 8);
    tick();
    check("t6_loop", 32'(seq_init), 32'd1);
    check("t6_mux_rr", 32'(mux_sel), 32'd3);
    cfg_continuous = 1'b0;
    expect_conv("t6b", 35, 1, 9, 16, 8);
    check("t6_cnt", 32'(conv_cnt), 32'd9);
    tick();
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_mux_end", 32'(mux_sel), 32'd4);

    // Asynchronous reset mid-SAMP
    pulse_start();
    tick();
    check("t7_in_samp", 32'(seq_samp), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_outs", all_outs(), 32'd0);
    check("t7_rst_cnt", 32'(conv_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
